// File: rtl/selfadd_feeder_if.sv
// selfadd_feeder_if: operand stream, accumulator link and window-sum stream of the feeder.
interface selfadd_feeder_if #(
  parameter int CW = 4
);
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [15:0]   s_a;
  logic [15:0]   s_b;
  logic          acc_data_v;
  logic          acc_usr_rst;
  logic          acc_sum_v;
  logic [15:0]   acc_in_a;
  logic [15:0]   acc_in_b;
  logic [15:0]   acc_sum_a;
  logic [15:0]   acc_sum_b;
  logic          m_valid;
  logic          m_ready;
  logic [15:0]   m_sum_a;
  logic [15:0]   m_sum_b;
  logic [CW-1:0] m_count;
  logic          err;
  modport master (
    input  s_valid, s_a, s_b, s_last, acc_sum_a, acc_sum_b, acc_sum_v, m_ready,
    output s_ready, acc_data_v, acc_in_a, acc_in_b, acc_usr_rst, m_valid, m_sum_a, m_sum_b,
           m_count, err
  );
  modport slave (
    output s_valid, s_a, s_b, s_last, acc_sum_a, acc_sum_b, acc_sum_v, m_ready,
    input  s_ready, acc_data_v, acc_in_a, acc_in_b, acc_usr_rst, m_valid, m_sum_a, m_sum_b,
           m_count, err
  );
endinterface

// File: rtl/selfadd_feeder.sv
// selfadd_feeder: issues operand pairs one at a time to a self-accumulating pair,
// collects the window sums and clears the accumulator between windows.
module selfadd_feeder #(
  parameter int WIN_LEN = 8,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 15,
  parameter int CW      = $clog2(WIN_LEN + 1)
) (
  input logic              clk,
  input logic              rst,
  selfadd_feeder_if.master bus
);
  localparam int CCW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {CLEAR, READY, ISSUE, WAIT, DRAIN} state_t;
  state_t         state_q, state_d;
  logic [CCW-1:0] clr_q, clr_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  m_count_q, m_count_d;
  logic [15:0]    in_a_q, in_a_d, in_b_q, in_b_d;
  logic [15:0]    m_sum_a_q, m_sum_a_d, m_sum_b_q, m_sum_b_d;
  logic           last_q, last_d;
  logic           err_q, err_d;
  logic           s_ready_q, data_v_q, usr_rst_q, m_valid_q;
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    m_count_d = m_count_q;
    in_a_d    = in_a_q;
    in_b_d    = in_b_q;
    m_sum_a_d = m_sum_a_q;
    m_sum_b_d = m_sum_b_q;
    last_d    = last_q;
    // a result outside WAIT has no issue to belong to
    err_d     = err_q | (bus.acc_sum_v && state_q != WAIT);
    case (state_q)
      CLEAR: begin
        cnt_d   = '0;
        clr_d   = (clr_q == CCW'(CLR_CYC - 1)) ? '0 : clr_q + 1'b1;
        state_d = (clr_q == CCW'(CLR_CYC - 1)) ? READY : CLEAR;
      end
      READY: begin
        if (bus.s_valid) begin
          in_a_d  = bus.s_a;
          in_b_d  = bus.s_b;
          last_d  = bus.s_last;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = cnt_q + 1'b1;
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.acc_sum_v) begin
          if (cnt_q == CW'(WIN_LEN) || last_q) begin
            m_sum_a_d = bus.acc_sum_a;
            m_sum_b_d = bus.acc_sum_b;
            m_count_d = cnt_q;
            state_d   = DRAIN;
          end else begin
            state_d = READY;
          end
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = CLEAR;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DRAIN: state_d = bus.m_ready ? CLEAR : DRAIN;
      default: state_d = CLEAR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_q     <= '0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      m_count_q <= '0;
      in_a_q    <= '0;
      in_b_q    <= '0;
      m_sum_a_q <= '0;
      m_sum_b_q <= '0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      s_ready_q <= 1'b0;
      data_v_q  <= 1'b0;
      usr_rst_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      m_count_q <= m_count_d;
      in_a_q    <= in_a_d;
      in_b_q    <= in_b_d;
      m_sum_a_q <= m_sum_a_d;
      m_sum_b_q <= m_sum_b_d;
      last_q    <= last_d;
      err_q     <= err_d;
      s_ready_q <= state_d == READY;
      data_v_q  <= state_d == ISSUE;
      usr_rst_q <= state_d == CLEAR;
      m_valid_q <= state_d == DRAIN;
    end
  end
  assign bus.s_ready     = s_ready_q;
  assign bus.acc_data_v  = data_v_q;
  assign bus.acc_usr_rst = usr_rst_q;
  assign bus.acc_in_a    = in_a_q;
  assign bus.acc_in_b    = in_b_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_sum_a     = m_sum_a_q;
  assign bus.m_sum_b     = m_sum_b_q;
  assign bus.m_count     = m_count_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_selfadd_feeder.sv
// tb_selfadd_feeder: vector table, corner sequences and a randomized run against a window-sum model.
module tb_selfadd_feeder;
  localparam int WIN_LEN = 4;
  localparam int CLR_CYC = 2;
  localparam int TIMEOUT = 15;
  localparam int CW      = 3;
  logic clk, rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  selfadd_feeder_if #(.CW(CW)) bus();
  selfadd_feeder #(.WIN_LEN(WIN_LEN), .CLR_CYC(CLR_CYC), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  // accumulator stand-in: adds on each issue, answers acc_lat cycles later
  int          acc_lat  = 4;
  bit          acc_drop = 1'b0;
  bit          spur_req = 1'b0;
  int          pend     = -1;
  logic [15:0] acc_a    = '0;
  logic [15:0] acc_b    = '0;
  initial begin
    bus.acc_sum_v = 1'b0;
    bus.acc_sum_a = '0;
    bus.acc_sum_b = '0;
    forever begin
      @(negedge clk);
      if (bus.acc_usr_rst) begin
        acc_a = '0;
        acc_b = '0;
        pend  = -1;
      end else if (bus.acc_data_v) begin
        acc_a = acc_a + bus.acc_in_a;
        acc_b = acc_b + bus.acc_in_b;
        pend  = acc_lat;
      end
      @(posedge clk);
      #1;
      bus.acc_sum_v = 1'b0;
      if (pend > 0) pend--;
      if (pend == 0) begin
        pend = -1;
        if (!acc_drop) begin
          bus.acc_sum_v = 1'b1;
          bus.acc_sum_a = acc_a;
          bus.acc_sum_b = acc_b;
        end
      end
      if (spur_req) bus.acc_sum_v = 1'b1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int t = 0;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_last  = last;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.s_ready && t < 60);
    chk("s_ready_wait", bus.s_ready, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask
  task automatic wait_sum_v();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.acc_sum_v && t < 40);
    chk("sum_v_wait", bus.acc_sum_v, 1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_usr_rst"}, bus.acc_usr_rst, 1);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_data_v"}, bus.acc_data_v, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_in_a"}, bus.acc_in_a, 0);
    chk({tag, "_in_b"}, bus.acc_in_b, 0);
    chk({tag, "_m_sum_a"}, bus.m_sum_a, 0);
    chk({tag, "_m_sum_b"}, bus.m_sum_b, 0);
    chk({tag, "_m_count"}, bus.m_count, 0);
  endtask
  // called at the negedge of a DRAIN cycle; expects CLR_CYC clear cycles then READY
  task automatic release_drain();
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    for (int i = 0; i < CLR_CYC; i++) begin
      @(negedge clk);
      chk("clear_usr_rst", bus.acc_usr_rst, 1);
      chk("clear_no_ready", bus.s_ready, 0);
      chk("clear_no_m_valid", bus.m_valid, 0);
    end
    @(negedge clk);
    chk("ready_after_clear", bus.s_ready, 1);
    chk("ready_usr_rst_off", bus.acc_usr_rst, 0);
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_pulse");
    repeat (CLR_CYC - 1) @(negedge clk);
    chk("rst_pulse_clearing", bus.acc_usr_rst, 1);
    @(negedge clk);
    chk("rst_pulse_ready", bus.s_ready, 1);
  endtask
  typedef struct {
    logic [15:0] a, b;
    logic        last, close;
    logic [15:0] ea, eb;
    logic [2:0]  ec;
  } vec_t;
  typedef struct {
    logic [15:0] a, b;
    int          c;
  } win_t;
  vec_t        vt[11];
  win_t        expq[$];
  logic [31:0] issq[$];
  initial begin
    vt[0]  = '{16'd1,      16'd2,      1'b0, 1'b0, 16'd0,   16'd0,   3'd0};
    vt[1]  = '{16'd3,      16'd4,      1'b0, 1'b0, 16'd0,   16'd0,   3'd0};
    vt[2]  = '{16'd5,      16'd6,      1'b0, 1'b0, 16'd0,   16'd0,   3'd0};
    vt[3]  = '{16'd7,      16'd8,      1'b0, 1'b1, 16'd16,  16'd20,  3'd4};
    vt[4]  = '{16'd10,     16'd20,     1'b1, 1'b1, 16'd10,  16'd20,  3'd1};
    vt[5]  = '{16'hFFFF,   16'd1,      1'b0, 1'b0, 16'd0,   16'd0,   3'd0};
    vt[6]  = '{16'd2,      16'hFFFF,   1'b1, 1'b1, 16'd1,   16'd0,   3'd2};
    vt[7]  = '{16'd100,    16'd200,    1'b0, 1'b0, 16'd0,   16'd0,   3'd0};
    vt[8]  = '{16'd1,      16'd1,      1'b0, 1'b0, 16'd0,   16'd0,   3'd0};
    vt[9]  = '{16'd1,      16'd1,      1'b0, 1'b0, 16'd0,   16'd0,   3'd0};
    vt[10] = '{16'd5,      16'd5,      1'b1, 1'b1, 16'd107, 16'd207, 3'd4};
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < CLR_CYC; i++) begin
      @(negedge clk);
      chk("por_clear_usr_rst", bus.acc_usr_rst, 1);
      chk("por_clear_no_ready", bus.s_ready, 0);
    end
    @(negedge clk);
    chk("por_ready", bus.s_ready, 1);
    // vector table: full window, early close, wraparound, last on the final slot
    for (int i = 0; i < 11; i++) begin
      send(vt[i].a, vt[i].b, vt[i].last);
      @(negedge clk);
      chk("issue_strobe", bus.acc_data_v, 1);
      chk("issue_a", bus.acc_in_a, vt[i].a);
      chk("issue_b", bus.acc_in_b, vt[i].b);
      wait_sum_v();
      @(negedge clk);
      if (vt[i].close) begin
        chk("tbl_m_valid", bus.m_valid, 1);
        chk("tbl_m_sum_a", bus.m_sum_a, vt[i].ea);
        chk("tbl_m_sum_b", bus.m_sum_b, vt[i].eb);
        chk("tbl_m_count", bus.m_count, vt[i].ec);
        chk("tbl_err", bus.err, 0);
        release_drain();
      end else begin
        chk("tbl_ready_back", bus.s_ready, 1);
        chk("tbl_no_m_valid", bus.m_valid, 0);
      end
    end
    // backpressure: DRAIN holds for 20 cycles
    send(16'd9, 16'd9, 1'b1);
    wait_sum_v();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_m_valid", bus.m_valid, 1);
      chk("bp_m_sum_a", bus.m_sum_a, 9);
      chk("bp_m_sum_b", bus.m_sum_b, 9);
      chk("bp_m_count", bus.m_count, 1);
      chk("bp_s_ready", bus.s_ready, 0);
    end
    release_drain();
    // result on the last tolerated wait cycle is accepted
    acc_lat = TIMEOUT;
    send(16'd2, 16'd3, 1'b1);
    wait_sum_v();
    @(negedge clk);
    chk("late_m_valid", bus.m_valid, 1);
    chk("late_m_sum_a", bus.m_sum_a, 2);
    chk("late_m_sum_b", bus.m_sum_b, 3);
    chk("late_err", bus.err, 0);
    release_drain();
    acc_lat = 4;
    // timeout: no result ever comes back
    acc_drop = 1'b1;
    send(16'd1, 16'd1, 1'b0);
    @(negedge clk);
    chk("to_issue", bus.acc_data_v, 1);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      chk("to_err_early", bus.err, 0);
      chk("to_no_m_valid", bus.m_valid, 0);
    end
    @(negedge clk);
    chk("to_err", bus.err, 1);
    chk("to_clear", bus.acc_usr_rst, 1);
    chk("to_no_m_valid_end", bus.m_valid, 0);
    @(negedge clk);
    chk("to_clear2", bus.acc_usr_rst, 1);
    @(negedge clk);
    chk("to_ready", bus.s_ready, 1);
    chk("to_err_sticky", bus.err, 1);
    acc_drop = 1'b0;
    // reset after 2 of 4 pairs, then the next window counts from 1
    for (int i = 0; i < 2; i++) begin
      send(16'd50, 16'd60, 1'b0);
      wait_sum_v();
      @(negedge clk);
      chk("mid_ready", bus.s_ready, 1);
    end
    pulse_reset();
    send(16'd3, 16'd7, 1'b1);
    wait_sum_v();
    @(negedge clk);
    chk("mid_m_valid", bus.m_valid, 1);
    chk("mid_m_sum_a", bus.m_sum_a, 3);
    chk("mid_m_sum_b", bus.m_sum_b, 7);
    chk("mid_m_count", bus.m_count, 1);
    release_drain();
    // spurious result while READY
    spur_req = 1'b1;
    @(negedge clk);
    spur_req = 1'b0;
    chk("spur_still_ready", bus.s_ready, 1);
    @(negedge clk);
    chk("spur_err", bus.err, 1);
    chk("spur_state_ready", bus.s_ready, 1);
    chk("spur_no_issue", bus.acc_data_v, 0);
    send(16'd4, 16'd5, 1'b1);
    wait_sum_v();
    @(negedge clk);
    chk("spur_next_m_sum_a", bus.m_sum_a, 4);
    chk("spur_next_m_sum_b", bus.m_sum_b, 5);
    chk("spur_next_m_count", bus.m_count, 1);
    chk("spur_err_sticky", bus.err, 1);
    release_drain();
    pulse_reset();
    // randomized traffic against a window-sum model
    begin
      logic [15:0] wa = '0, wb = '0, pa = '0, pb = '0;
      int          wc = 0, nwin = 0;
      logic        fire, hold = 1'b0;
      logic [2:0]  pc = '0;
      win_t        w;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        @(negedge clk);
        fire = bus.s_valid && bus.s_ready;
        if (fire) begin
          issq.push_back({bus.s_a, bus.s_b});
          wa = wa + bus.s_a;
          wb = wb + bus.s_b;
          wc++;
          if (wc == WIN_LEN || bus.s_last) begin
            expq.push_back('{wa, wb, wc});
            wa = '0;
            wb = '0;
            wc = 0;
          end
        end
        if (bus.acc_data_v) begin
          chk("rnd_issue_pending", issq.size() > 0, 1);
          if (issq.size() > 0) chk("rnd_issue_ops", {bus.acc_in_a, bus.acc_in_b}, issq.pop_front());
        end
        if (hold) begin
          chk("rnd_hold_valid", bus.m_valid, 1);
          chk("rnd_hold_sums", {bus.m_sum_a, bus.m_sum_b}, {pa, pb});
          chk("rnd_hold_count", bus.m_count, pc);
        end
        if (bus.m_valid && bus.m_ready) begin
          chk("rnd_win_pending", expq.size() > 0, 1);
          if (expq.size() > 0) begin
            w = expq.pop_front();
            chk("rnd_m_sum_a", bus.m_sum_a, w.a);
            chk("rnd_m_sum_b", bus.m_sum_b, w.b);
            chk("rnd_m_count", bus.m_count, w.c);
            nwin++;
          end
        end
        hold = bus.m_valid && !bus.m_ready;
        pa   = bus.m_sum_a;
        pb   = bus.m_sum_b;
        pc   = bus.m_count;
        @(posedge clk);
        #1;
        if (fire || !bus.s_valid) begin
          bus.s_valid = ($urandom_range(0, 2) != 0);
          bus.s_a     = 16'($urandom);
          bus.s_b     = 16'($urandom);
          bus.s_last  = ($urandom_range(0, 4) == 0);
        end
        bus.m_ready = ($urandom_range(0, 1) == 1);
        acc_lat     = $urandom_range(1, 8);
      end
      chk("rnd_windows_seen", nwin > 20, 1);
      chk("rnd_err", bus.err, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
